pipe_stage_fifo: RTL and testbench
==================================

# pipe_stage_fifo

Parametrised elastic pipeline-stage register: the successor to the fixed enable/stall/flush stage registers between pipeline stages. It carries a WIDTH-bit stage payload through a DEPTH-entry circular buffer with a valid/ready handshake on both sides, so stalls are absorbed locally instead of being broadcast. It has a synchronous flush for branch/exception squash and sits between any two stages, e.g. EX→MEM.

## Interface

Parameters:
- WIDTH, 64: payload width in bits (≥1).
- DEPTH, 2: buffer entries (≥1). DEPTH≥2 gives full throughput.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; reset==0 at a clk edge clears all state.
- flush  in  1  squash all buffered entries; any same-cycle input is dropped.
- in_valid  in  1  upstream has payload.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  buffer can accept this cycle.
- out_valid  out  1  head entry valid.
- out_data  out  WIDTH  head entry payload.
- out_ready  in  1  downstream accepts head this cycle.
- count  out  $clog2(DEPTH+1)  occupied entries.
- stall_cnt  out  32  upstream backpressure cycle counter (see Configuration).

## Operation

- Storage is mem[DEPTH] with wr_ptr and rd_ptr in 0..DEPTH-1, plus count.
- Both pointers wrap from DEPTH-1 to 0. DEPTH need not be a power of two.
- push = in_valid && in_ready && !flush.
- pop = out_valid && out_ready && !flush.
- Push writes mem[wr_ptr] and advances wr_ptr.
- Pop advances rd_ptr.
- count next = count + push − pop. Simultaneous push and pop leaves count unchanged.
- in_ready = (count < DEPTH). It depends only on registered state. There is no combinational in_valid/out_ready→in_ready path.
- out_valid = (count != 0).
- out_data = mem[rd_ptr]. It is only meaningful when out_valid=1.
- Full (count==DEPTH): in_ready=0. out_ready=1 frees a slot visible the next cycle.
- Empty: out_valid=0. out_ready is ignored.
- Flush, takes priority over push and pop:
  - next state: count=0, wr_ptr=rd_ptr=0;
  - mem contents are left untouched.
- Reset, takes priority over flush:
  - count=0, pointers=0, all mem entries='0, stall_cnt=0.
- Reset asserted mid-transfer discards everything. There is no partial drain.

## Timing

- Latency: payload accepted at edge N is on out_data with out_valid=1 from edge N onward. That is 1 cycle from the in_valid cycle.
- Throughput:
  - DEPTH≥2: one transfer per cycle sustained with out_ready=1.
  - DEPTH=1: at most one transfer every 2 cycles.
- Order is strictly FIFO.
- After flush at edge N: out_valid=0 and in_ready=1 during cycle N+1. A push is possible in cycle N+1.
- Reset values of outputs: in_ready=1, out_valid=0, out_data='0, count=0, stall_cnt=0.

## Configuration

- Macro: PIPE_STAGE_FIFO_PERF_EN.
- Defined:
  - stall_cnt increments by 1 on every cycle with in_valid=1 && in_ready=0 && flush=0.
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared only by reset; flush does not clear it.
- Undefined:
  - no counter logic is instantiated;
  - stall_cnt is tied to 32'h0;
  - all other behaviour is identical.

## Test plan

- Reset and fill, WIDTH=8, DEPTH=2: hold reset=0 for 2 cycles, then push 0xA1 and 0xA2 with out_ready=0.
  - Required: count 0→1→2; in_ready drops to 0 after the second edge.
  - Required: out_valid=1 with out_data=0xA1.
- Streaming: push 0x01..0x10 on consecutive cycles with out_ready=1.
  - Required: 16 pops in order with zero bubbles after the first.
  - Required: count stays at 1.
- Full plus simultaneous pop: at count=2, assert in_valid=1 with 0xB3 and out_ready=1.
  - Required: 0xA1 popped, 0xB3 not accepted (in_ready=0), count=1.
  - Required: next cycle in_ready=1 and 0xB3 is accepted.
- Flush with input: at count=2, assert flush=1 with in_valid=1 and 0xC4.
  - Required: next cycle count=0, out_valid=0, in_ready=1.
  - Required: 0xC4 never appears on out_data.
- Wrap-around, DEPTH=3: push and pop 7 items with out_ready toggling 1,0,1,0.
  - Required: output order is exact and pointers wrap 2→0 without loss or duplication.
- Perf counter (PIPE_STAGE_FIFO_PERF_EN defined): hold in_valid=1 at full for 5 cycles with out_ready=0.
  - Required: stall_cnt=5.
  - Required: stall_cnt=5 still after a flush.
  - Required: stall_cnt=0 after reset.
  - Required with the macro undefined: stall_cnt=0 throughout.

Source files
------------

// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline-stage register: DEPTH-entry circular buffer with
// valid/ready on both sides and a synchronous squash (flush).
//
// Ports: clk, reset (sync, active-low), flush,
//   in_valid/in_data/in_ready (upstream), out_valid/out_data/out_ready
//   (downstream), count (occupancy), stall_cnt (upstream backpressure).
// Optional: define PIPE_STAGE_FIFO_PERF_EN to build the saturating
//   stall counter; otherwise stall_cnt is tied to zero.
module pipe_stage_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic [31:0]      stall_cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready comes from registered occupancy only: no in->out comb path.
  assign in_ready  = cnt < CW'(DEPTH);
  assign out_valid = cnt != '0;
  assign out_data  = mem[rd_ptr];
  assign count     = cnt;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      // Squash keeps mem; entries become unreachable.
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop)
        rd_ptr <= nxt(rd_ptr);
      unique case (1'b1)
        push && !pop: cnt <= cnt + 1'b1;
        pop && !push: cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PIPE_STAGE_FIFO_PERF_EN
  logic [31:0] stall_q;

  // Saturating; flush does not clear it.
  always_ff @(posedge clk) begin
    if (!reset)
      stall_q <= '0;
    else if (in_valid && !in_ready && !flush
             && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: directed table on DEPTH=2, sequences
// for streaming/wrap, random traffic on DEPTH=1,2,3 vs a list model.
module tb_pipe_stage_fifo;

`ifdef PIPE_STAGE_FIFO_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic        fl   [3];
  logic        iv   [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic [7:0]  id   [3];
  logic [7:0]  od   [3];
  logic [2:0]  cn   [3];
  logic [31:0] sc   [3];

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int CW = $clog2(g + 2);
    logic [CW-1:0] c;
    pipe_stage_fifo #(.WIDTH(8), .DEPTH(g + 1)) u (
      .clk(clk), .reset(rst[g]), .flush(fl[g]),
      .in_valid(iv[g]), .in_data(id[g]), .in_ready(ir[g]),
      .out_valid(ov[g]), .out_data(od[g]),
      .out_ready(ordy[g]), .count(c), .stall_cnt(sc[g])
    );
    assign cn[g] = 3'(c);
  end

  int nvec = 0;
  int nmis = 0;

  task automatic cmp(string nm, logic [44:0] act, logic [44:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // {in_ready, out_valid, out_data, count, stall_cnt}
  function automatic logic [44:0] pk(logic r, logic v,
      logic [7:0] d, logic [2:0] c, logic [31:0] s);
    return {r, v, d, c, s};
  endfunction

  typedef struct {
    logic rs, f, v; logic [7:0] d; logic o;
    logic er, ev, cd; logic [7:0] ed;
    logic [2:0] ec; logic [31:0] es;
  } vec_t;

  function automatic vec_t mk(logic rs, logic f, logic v,
      logic [7:0] d, logic o, logic er, logic ev, logic cd,
      logic [7:0] ed, logic [2:0] ec, logic [31:0] es);
    vec_t t;
    t.rs = rs; t.f = f; t.v = v; t.d = d; t.o = o;
    t.er = er; t.ev = ev; t.cd = cd; t.ed = ed;
    t.ec = ec; t.es = es;
    return t;
  endfunction

  // Reference model: an ordered list per instance, head at index 0.
  logic [7:0]  ml [3][4];
  int          mlen [3];
  logic [31:0] ms [3];

  task automatic step(int g);
    bit rdy = mlen[g] < g + 1;
    bit vld = mlen[g] != 0;
    if (!rst[g]) begin
      mlen[g] = 0;
      ms[g] = 0;
    end else begin
      if (iv[g] && !rdy && !fl[g] && ms[g] != 32'hFFFF_FFFF)
        ms[g]++;
      if (fl[g]) mlen[g] = 0;
      else begin
        if (vld && ordy[g]) begin
          for (int k = 0; k < 3; k++) ml[g][k] = ml[g][k+1];
          mlen[g]--;
        end
        if (iv[g] && rdy) begin
          ml[g][mlen[g]] = id[g];
          mlen[g]++;
        end
      end
    end
  endtask

  task automatic chk(int g, int cyc);
    bit v = mlen[g] != 0;
    logic [44:0] e, a;
    e = pk(mlen[g] < g + 1, v, v ? ml[g][0] : 8'h0,
           3'(mlen[g]), PERF ? ms[g] : 32'h0);
    a = pk(ir[g], ov[g], v ? od[g] : 8'h0, cn[g], sc[g]);
    cmp($sformatf("rnd_d%0d_c%0d", g + 1, cyc), a, e);
  endtask

  vec_t tbl [19];

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst[g] = 0; fl[g] = 0; iv[g] = 0;
      ordy[g] = 0; id[g] = 0; mlen[g] = 0; ms[g] = 0;
    end

    tbl[0]  = mk(0,0,0,8'h00,0, 1,0,1,8'h00,0,0);
    tbl[1]  = mk(0,0,1,8'h55,1, 1,0,1,8'h00,0,0);
    tbl[2]  = mk(1,0,1,8'hA1,0, 1,1,1,8'hA1,1,0);
    tbl[3]  = mk(1,0,1,8'hA2,0, 0,1,1,8'hA1,2,0);
    for (int k = 0; k < 5; k++)
      tbl[4+k] = mk(1,0,1,8'hEE,0, 0,1,1,8'hA1,2,k+1);
    tbl[9]  = mk(1,1,1,8'hC4,1, 1,0,0,8'h00,0,5);
    tbl[10] = mk(1,0,0,8'h00,1, 1,0,0,8'h00,0,5);
    tbl[11] = mk(0,0,0,8'h00,0, 1,0,1,8'h00,0,0);
    tbl[12] = mk(1,0,1,8'hA1,0, 1,1,1,8'hA1,1,0);
    tbl[13] = mk(1,0,1,8'hA2,0, 0,1,1,8'hA1,2,0);
    tbl[14] = mk(1,0,1,8'hB3,1, 1,1,1,8'hA2,1,1);
    tbl[15] = mk(1,0,1,8'hB3,0, 0,1,1,8'hA2,2,1);
    tbl[16] = mk(1,1,1,8'hC4,0, 1,0,0,8'h00,0,1);
    tbl[17] = mk(1,0,1,8'hD5,0, 1,1,1,8'hD5,1,1);
    tbl[18] = mk(1,0,0,8'h00,1, 1,0,0,8'h00,0,1);

    // Directed table on DEPTH=2.
    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      rst[1] = tbl[i].rs; fl[1] = tbl[i].f;
      iv[1] = tbl[i].v; id[1] = tbl[i].d;
      ordy[1] = tbl[i].o;
      @(negedge clk);
      cmp($sformatf("row%0d", i),
          pk(ir[1], ov[1], tbl[i].cd ? od[1] : 8'h0,
             cn[1], sc[1]),
          pk(tbl[i].er, tbl[i].ev, tbl[i].cd ? tbl[i].ed : 8'h0,
             tbl[i].ec, PERF ? tbl[i].es : 32'h0));
    end

    // Streaming 0x01..0x10 with out_ready=1: no bubbles.
    for (int k = 1; k <= 16; k++) begin
      iv[1] = 1; id[1] = 8'(k); ordy[1] = 1;
      @(negedge clk);
      cmp($sformatf("stream%0d", k),
          pk(ir[1], ov[1], od[1], cn[1], sc[1]),
          pk(1, 1, 8'(k), 1, PERF ? 32'd1 : 32'd0));
    end
    iv[1] = 0;
    @(negedge clk);
    cmp("stream_drain", pk(ir[1], ov[1], 8'h0, cn[1], sc[1]),
        pk(1, 0, 8'h0, 0, PERF ? 32'd1 : 32'd0));

    // Wrap-around on DEPTH=3 with out_ready toggling.
    rst[2] = 1;
    begin
      int sent = 0;
      int got = 0;
      int cyc = 0;
      while (got < 7 && cyc < 60) begin
        @(negedge clk);
        ordy[2] = (cyc % 2) == 0;
        iv[2] = sent < 7;
        id[2] = 8'(8'h71 + sent);
        if (ov[2] && ordy[2]) begin
          cmp($sformatf("wrap%0d", got), {37'h0, od[2]},
              {37'h0, 8'(8'h71 + got)});
          got++;
        end
        if (iv[2] && ir[2]) sent++;
        cyc++;
      end
      cmp("wrap_done", 45'(got), 45'd7);
    end

    // Random traffic on all depths vs the list model.
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (cyc > 0) chk(g, cyc);
        rst[g] = (cyc == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
        fl[g] = $urandom_range(0, 15) == 0;
        iv[g] = $urandom_range(0, 9) < 7;
        id[g] = 8'($urandom);
        ordy[g] = $urandom_range(0, 9) < 6;
        step(g);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
